alu_issue_arbiter: RTL and testbench
====================================

Name: alu_issue_arbiter

Overview:
- Schedules the single shared ALU/CDB-write path among NUM_RS reservation stations.
- Each station raises a request when both operands are valid. The arbiter grants one station per cycle by round-robin and latches the winner's ALU word and control flags into an output issue register that feeds the ALU.
- Requests whose ROB entry has been deallocated (flush) are ignored, and a held issue is cancelled.
- Stations hold their word until granted.

Parameters:
- NUM_RS, 5, number of requesting reservation stations (2..8).
- WORD_W, 106, width of one packed alu_word.
- TAG_W, 3, ROB tag width; ROB depth = 2**TAG_W.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NUM_RS  per-station request; operands ready.
- req_word  in  NUM_RS*WORD_W  packed alu_word per station; station i occupies bits [i*WORD_W +: WORD_W].
- req_tag  in  NUM_RS*TAG_W  destination ROB tag per station.
- req_flags  in  NUM_RS*3  per station {jalr_executed, ld_pc_to_cdb, update_br}.
- allocated_rob_entries  in  2**TAG_W  ROB valid bitmap.
- alu_ready  in  1  ALU accepts the issue register this cycle.
- grant  out  NUM_RS  one-hot, combinational; station i may drop its word at this edge.
- issue_valid  out  1  issue register holds a live op.
- issue_word  out  WORD_W  registered alu_word.
- issue_tag  out  TAG_W  registered ROB tag.
- issue_flags  out  3  registered {jalr_executed, ld_pc_to_cdb, update_br}.
- issue_count  out  32  number of ops accepted by the ALU; wraps.

Behaviour:
- **Reset (rst=0, async):**
  - issue_valid=0; issue_word, issue_tag, issue_flags = 0.
  - rr_ptr=0; issue_count=0.
  - grant=0 while rst=0.
- **Eligibility:** eligible[i] = req[i] & allocated_rob_entries[req_tag[i]].
- **Issue register state:**
  - IDLE: issue_valid=0.
  - HOLD: issue_valid=1.
  - consume = issue_valid & alu_ready.
  - kill = issue_valid & ~allocated_rob_entries[issue_tag].
  - can_load = ~issue_valid | consume | kill.
- **Arbitration:** if can_load and any eligible bit is set, the winner is the first eligible index scanning rr_ptr, rr_ptr+1, ... with wrap modulo NUM_RS. grant[winner]=1; all other grant bits are 0.
- **Edge update on a grant:**
  - Issue register loads the winner's word, tag and flags; issue_valid=1.
  - rr_ptr <= (winner+1) mod NUM_RS; winner NUM_RS-1 wraps rr_ptr to 0.
- **Edge update without a grant:**
  - If consume or kill, issue_valid <= 0.
  - Otherwise the register holds, and all outputs stay stable.
  - rr_ptr is unchanged.
- **Counting:** consume & ~kill increments issue_count by 1; 0xFFFFFFFF wraps to 0. A killed op is never counted, even if alu_ready=1.
- **Latency:** request to issue_valid is 1 cycle. Back-to-back issues are sustained at 1 op/cycle while alu_ready=1.
- **Fairness:** with alu_ready=1 held continuously, an eligible station is granted within NUM_RS cycles.
- **Simultaneous kill and new grant:** the new op overwrites the killed one; there is no bubble.
- **Ineligible request:** the station is never granted, and its req does not affect rr_ptr.
- **Reset mid-hold:** the op is discarded immediately. The station already dropped it at grant, so the flush logic of the ROB owns recovery.

Test Plan:
- **Reset:** rst=0 then release with req=0 -> issue_valid=0, grant=0, issue_count=0 held for 5 cycles.
- **Single request:** req=5'b00100, tag=3, allocated[3]=1, alu_ready=1 -> grant=5'b00100 in the same cycle; next cycle issue_valid=1, issue_tag=3; issue_count=1 one cycle later.
- **Round-robin:** all 5 request continuously with alu_ready=1 -> grant sequence 0,1,2,3,4,0; rr_ptr wraps after index 4.
- **Back-pressure:** alu_ready=0 with issue_valid=1 and req=5'b00011 -> grant=0 and issue_word stable for 4 cycles. When alu_ready rises, grant goes to station 1 if rr_ptr=1.
- **Flush:** held op with tag 6, then deallocate ROB entry 6 while alu_ready=0 -> next cycle issue_valid=0, issue_count unchanged. A pending req with tag 6 is never granted.
- **Wrap:** preload issue_count=0xFFFFFFFF via 2**32-1 accepted ops (or a force), issue one more op -> issue_count=0.

Source files
------------

// File: rtl/alu_issue_arbiter.sv
// Round-robin issue arbiter for the shared ALU/CDB-write path.
// Picks one eligible reservation station per cycle and holds its op in an issue register.
module alu_issue_arbiter #(
    parameter int unsigned NUM_RS = 5,
    parameter int unsigned WORD_W = 106,
    parameter int unsigned TAG_W  = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RS-1:0]          req,
    input  logic [NUM_RS*WORD_W-1:0]   req_word,
    input  logic [NUM_RS*TAG_W-1:0]    req_tag,
    input  logic [NUM_RS*3-1:0]        req_flags,
    input  logic [2**TAG_W-1:0]        allocated_rob_entries,
    input  logic                       alu_ready,
    output logic [NUM_RS-1:0]          grant,
    output logic                       issue_valid,
    output logic [WORD_W-1:0]          issue_word,
    output logic [TAG_W-1:0]           issue_tag,
    output logic [2:0]                 issue_flags,
    output logic [31:0]                issue_count
);

    localparam int unsigned PTR_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e              state_q;
    logic [PTR_W-1:0]    rr_ptr_q;
    logic [PTR_W-1:0]    rr_ptr_d;
    logic [WORD_W-1:0]   issue_word_q;
    logic [TAG_W-1:0]    issue_tag_q;
    logic [2:0]          issue_flags_q;
    logic [31:0]         issue_count_q;

    logic [NUM_RS-1:0]   eligible;
    logic [PTR_W-1:0]    winner;
    logic                found;
    logic                consume;
    logic                kill;
    logic                can_load;
    logic                load;
    int unsigned         idx;

    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NUM_RS; i++) begin
            eligible[i] = req[i] & allocated_rob_entries[req_tag[i*TAG_W +: TAG_W]];
        end
    end

    assign issue_valid = (state_q == HOLD);
    assign consume     = issue_valid & alu_ready;
    assign kill        = issue_valid & ~allocated_rob_entries[issue_tag_q];
    assign can_load    = ~issue_valid | consume | kill;

    // Scan from rr_ptr upward with wrap; the first eligible index wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned k = 0; k < NUM_RS; k++) begin
            idx = (32'(rr_ptr_q) + k) % NUM_RS;
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = idx[PTR_W-1:0];
            end
        end
    end

    assign load = rst & can_load & found;

    always_comb begin
        grant = '0;
        if (load) begin
            grant[winner] = 1'b1;
        end
    end

    assign rr_ptr_d = (winner == PTR_W'(NUM_RS - 1)) ? '0 : winner + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            issue_word_q  <= '0;
            issue_tag_q   <= '0;
            issue_flags_q <= '0;
            issue_count_q <= '0;
        end else begin
            if (load) begin
                state_q       <= HOLD;
                rr_ptr_q      <= rr_ptr_d;
                issue_word_q  <= req_word[winner*WORD_W +: WORD_W];
                issue_tag_q   <= req_tag[winner*TAG_W +: TAG_W];
                issue_flags_q <= req_flags[winner*3 +: 3];
            end else if (consume || kill) begin
                state_q <= IDLE;
            end
            // A killed op never reaches the CDB, so it is not counted.
            if (consume && !kill) begin
                issue_count_q <= issue_count_q + 32'd1;
            end
        end
    end

    assign issue_word  = issue_word_q;
    assign issue_tag   = issue_tag_q;
    assign issue_flags = issue_flags_q;
    assign issue_count = issue_count_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: vector table for arbitration plus hand sequences for flush,
// reset-in-hold and counter wrap; issued ops are checked against a scoreboard queue.
module tb_alu_issue_arbiter;

    localparam int unsigned NRS = 5;
    localparam int unsigned WW  = 106;
    localparam int unsigned TW  = 3;

    logic              clk;
    logic              rst;
    logic [NRS-1:0]    req;
    logic [NRS*WW-1:0] req_word;
    logic [NRS*TW-1:0] req_tag;
    logic [NRS*3-1:0]  req_flags;
    logic [7:0]        alloc;
    logic              alu_ready;
    logic [NRS-1:0]    grant;
    logic              issue_valid;
    logic [WW-1:0]     issue_word;
    logic [TW-1:0]     issue_tag;
    logic [2:0]        issue_flags;
    logic [31:0]       issue_count;

    alu_issue_arbiter #(.NUM_RS(NRS), .WORD_W(WW), .TAG_W(TW)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .req                   (req),
        .req_word              (req_word),
        .req_tag               (req_tag),
        .req_flags             (req_flags),
        .allocated_rob_entries (alloc),
        .alu_ready             (alu_ready),
        .grant                 (grant),
        .issue_valid           (issue_valid),
        .issue_word            (issue_word),
        .issue_tag             (issue_tag),
        .issue_flags           (issue_flags),
        .issue_count           (issue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [WW-1:0] w;
        logic [TW-1:0] t;
        logic [2:0]    f;
    } exp_t;

    typedef struct {
        logic [NRS-1:0] r;
        logic           rdy;
        logic [7:0]     al;
        logic [NRS-1:0] g;
    } vec_t;

    exp_t        sbq[$];
    vec_t        tbl[17];
    logic [2:0]  tag_a[NRS];
    int          n_chk;
    int          n_fail;

    logic        held_valid;
    exp_t        held;
    logic [31:0] exp_count;

    function automatic logic [WW-1:0] word_of(input int unsigned i);
        logic [WW-1:0] w;
        w = {53'h0_0000_DEAD_BEEF + 53'(i), 53'h1A_5A5A_5A5A_5A5A ^ 53'(i * 7)};
        return w;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive_static();
        for (int i = 0; i < NRS; i++) begin
            req_word[i*WW +: WW] = word_of(i);
            req_tag[i*TW +: TW]  = tag_a[i];
            req_flags[i*3 +: 3]  = 3'(i + 1);
        end
    endtask

    // One cycle: drive at negedge, check grant, predict edge, check issue register after posedge.
    task automatic step(input logic [NRS-1:0] r, input logic rdy, input logic [7:0] al,
                        input logic [NRS-1:0] g, input string nm);
        logic cons;
        logic kl;
        exp_t e;
        @(negedge clk);
        drive_static();
        req       = r;
        alu_ready = rdy;
        alloc     = al;
        #1;
        chk({nm, ".grant"}, 128'(grant), 128'(g));
        cons = held_valid & rdy;
        kl   = held_valid & ~al[held.t];
        if (cons && !kl) exp_count = exp_count + 32'd1;
        if (g != '0) begin
            for (int i = 0; i < NRS; i++) begin
                if (g[i]) begin
                    e.w = word_of(i);
                    e.t = tag_a[i];
                    e.f = 3'(i + 1);
                end
            end
            sbq.push_back(e);
        end else if (cons || kl) begin
            held_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            held_valid = 1'b1;
            held = e;
        end
        chk({nm, ".valid"}, 128'(issue_valid), 128'(held_valid));
        if (held_valid) begin
            chk({nm, ".word"}, 128'(issue_word), 128'(held.w));
            chk({nm, ".tag"}, 128'(issue_tag), 128'(held.t));
            chk({nm, ".flags"}, 128'(issue_flags), 128'(held.f));
        end
        chk({nm, ".count"}, 128'(issue_count), 128'(exp_count));
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        held_valid = 1'b0;
        held       = '0;
        exp_count  = '0;
        for (int i = 0; i < NRS; i++) tag_a[i] = 3'(i + 1);

        // Round-robin, back-pressure and ineligible-request vectors, starting from rr_ptr=0.
        tbl[0]  = '{5'b11111, 1'b1, 8'hFF, 5'b00001};
        tbl[1]  = '{5'b11111, 1'b1, 8'hFF, 5'b00010};
        tbl[2]  = '{5'b11111, 1'b1, 8'hFF, 5'b00100};
        tbl[3]  = '{5'b11111, 1'b1, 8'hFF, 5'b01000};
        tbl[4]  = '{5'b11111, 1'b1, 8'hFF, 5'b10000};
        tbl[5]  = '{5'b11111, 1'b1, 8'hFF, 5'b00001};
        tbl[6]  = '{5'b00011, 1'b0, 8'hFF, 5'b00000};
        tbl[7]  = '{5'b00011, 1'b0, 8'hFF, 5'b00000};
        tbl[8]  = '{5'b00011, 1'b0, 8'hFF, 5'b00000};
        tbl[9]  = '{5'b00011, 1'b0, 8'hFF, 5'b00000};
        tbl[10] = '{5'b00011, 1'b1, 8'hFF, 5'b00010};
        tbl[11] = '{5'b00011, 1'b1, 8'hFF, 5'b00001};
        tbl[12] = '{5'b00100, 1'b1, 8'hF7, 5'b00000};
        tbl[13] = '{5'b00110, 1'b1, 8'hF7, 5'b00010};
        tbl[14] = '{5'b00100, 1'b1, 8'hF7, 5'b00000};
        tbl[15] = '{5'b10001, 1'b1, 8'hFF, 5'b10000};
        tbl[16] = '{5'b00001, 1'b1, 8'hFF, 5'b00001};

        rst       = 1'b0;
        req       = '1;
        alloc     = 8'hFF;
        alu_ready = 1'b1;
        drive_static();
        #23;
        chk("rst.grant", 128'(grant), 128'(0));
        chk("rst.valid", 128'(issue_valid), 128'(0));
        chk("rst.count", 128'(issue_count), 128'(0));
        chk("rst.word", 128'(issue_word), 128'(0));
        @(negedge clk);
        req = '0;
        rst = 1'b1;
        for (int c = 0; c < 5; c++) step(5'b00000, 1'b1, 8'hFF, 5'b00000, "idle");

        for (int v = 0; v < 17; v++) begin
            step(tbl[v].r, tbl[v].rdy, tbl[v].al, tbl[v].g, $sformatf("vec%0d", v));
        end

        // Single request from station 2 (tag 3); count rises once it is accepted.
        step(5'b00100, 1'b1, 8'hFF, 5'b00100, "single");
        step(5'b00000, 1'b1, 8'hFF, 5'b00000, "single_acc");

        // Flush of a held op with tag 6, then kill coinciding with a new grant.
        tag_a[3] = 3'd6;
        step(5'b01000, 1'b1, 8'hFF, 5'b01000, "fl_issue");
        step(5'b00000, 1'b0, 8'hFF, 5'b00000, "fl_hold");
        step(5'b01000, 1'b0, 8'hBF, 5'b00000, "fl_kill");
        step(5'b01000, 1'b0, 8'hBF, 5'b00000, "fl_never");
        step(5'b01000, 1'b1, 8'hFF, 5'b01000, "kg_issue");
        step(5'b00001, 1'b0, 8'hBF, 5'b00001, "kg_swap");
        tag_a[3] = 3'd4;
        step(5'b00000, 1'b1, 8'hFF, 5'b00000, "kg_acc");

        // Reset while holding discards the op at once.
        step(5'b00001, 1'b0, 8'hFF, 5'b00001, "rh_issue");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rh.valid", 128'(issue_valid), 128'(0));
        chk("rh.grant", 128'(grant), 128'(0));
        chk("rh.count", 128'(issue_count), 128'(0));
        @(negedge clk);
        rst        = 1'b1;
        req        = '0;
        held_valid = 1'b0;
        exp_count  = '0;
        sbq.delete();

        // Counter wrap from all-ones.
        @(negedge clk);
        force dut.issue_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.issue_count_q;
        exp_count = 32'hFFFF_FFFF;
        chk("wrap.preload", 128'(issue_count), 128'(exp_count));
        step(5'b00001, 1'b1, 8'hFF, 5'b00001, "wrap_issue");
        step(5'b00000, 1'b1, 8'hFF, 5'b00000, "wrap_acc");
        chk("wrap.zero", 128'(issue_count), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
